// File: rtl/block_data_memory.sv
// Line-granular backing store behind the data cache: one outstanding line read or
// write, completed a fixed DELAY cycles after acceptance, with a valid/ready handshake.
module block_data_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 256,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int LINE_W = BLOCK_SIZE * 8;
  localparam int OFF_W  = $clog2(BLOCK_SIZE / 4);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_op_read;
  logic [IDX_W-1:0]    r_idx;
  logic [LINE_W-1:0]   r_din;
  logic [LINE_W-1:0]   r_mem [NUM_BLOCKS];
  logic                r_valid;
  logic [LINE_W-1:0]   r_dout;

  logic                w_accept;
  logic                w_done;
  logic [IDX_W-1:0]    w_idx;
  logic                w_unused_addr;

  // Word-offset bits and index bits above the array size are don't-care.
  assign w_idx         = addr[OFF_W +: IDX_W];
  assign w_unused_addr = ^{addr[31:OFF_W+IDX_W], addr[OFF_W-1:0]};

  assign w_accept = (r_state == IDLE) && is_input_valid && (mem_read ^ mem_write);
  assign w_done   = (r_state == BUSY) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        mem_ready = 1'b1;
        if (w_accept) begin
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_op_read <= 1'b0;
      r_idx     <= '0;
      r_din     <= '0;
    end else if (w_accept) begin
      r_cnt     <= CNT_W'(DELAY - 1);
      r_op_read <= mem_read;
      r_idx     <= w_idx;
      r_din     <= din;
    end else if (r_state == BUSY && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Writes commit only at completion so a reset mid-request discards them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_done && !r_op_read) begin
      r_mem[r_idx] <= r_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_valid <= w_done && r_op_read;
      if (w_done && r_op_read) begin
        r_dout <= r_mem[r_idx];
      end
    end
  end

  assign is_output_valid = r_valid;
  assign dout            = r_dout;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: vector table for line reads/writes plus
// hand-written sequences for bus noise while busy, illegal ops, reset abort and back-to-back.
module tb_block_data_memory;

  localparam int DELAY = 50;
  localparam int LIMIT = 200;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] din;
  logic         is_output_valid;
  logic [127:0] dout;
  logic         mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  block_data_memory #(
    .BLOCK_SIZE(16),
    .NUM_BLOCKS(256),
    .DELAY(DELAY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .is_input_valid(is_input_valid),
    .addr(addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .din(din),
    .is_output_valid(is_output_valid),
    .dout(dout),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    bit           rd;
    logic [31:0]  a;
    logic [127:0] d;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] LINE_T2 = 128'hDEADBEEF_00000001_00000002_00000003;
  localparam logic [127:0] LINE_A  = 128'hA5A5A5A5_01234567_89ABCDEF_5A5A5A5A;
  localparam logic [127:0] LINE_B  = 128'hFEEDFACE_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] LINE_C  = 128'h0F0F0F0F_F0F0F0F0_11223344_55667788;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    addr           = '1;
    din            = {4{32'hBADC0FFE}};
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_req(input bit rd, input logic [31:0] a, input logic [127:0] d);
    is_input_valid = 1'b1;
    mem_read       = rd;
    mem_write      = !rd;
    addr           = a;
    din            = d;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  // Counts negedges with mem_ready low; ends on the completion-visible negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!mem_ready && lat < LIMIT) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input bit rd, input logic [31:0] a,
                        input logic [127:0] d, input logic [127:0] exp);
    int lat;
    chk({name, "_ready_before"}, 128'(mem_ready), 128'(1));
    start_req(rd, a, d);
    wait_done(lat);
    chk({name, "_latency"}, 128'(lat), 128'(DELAY));
    chk({name, "_valid_at_done"}, 128'(is_output_valid), 128'(rd));
    if (rd) chk({name, "_dout"}, dout, exp);
    @(negedge clk);
    chk({name, "_valid_after"}, 128'(is_output_valid), 128'(0));
  endtask

  initial begin
    int lat;
    int spurious;

    vecs[0] = '{"t1_read_blk5_zero", 1'b1, 32'h14,  '0,      '0};
    vecs[1] = '{"t2_write_0x14",     1'b0, 32'h14,  LINE_T2, '0};
    vecs[2] = '{"t2_read_0x17",      1'b1, 32'h17,  '0,      LINE_T2};
    vecs[3] = '{"t6_write_0x400",    1'b0, 32'h400, LINE_A,  '0};
    vecs[4] = '{"t6_read_0x000",     1'b1, 32'h0,   '0,      LINE_A};
    vecs[5] = '{"write_blk255",      1'b0, 32'h3FC, LINE_B,  '0};
    vecs[6] = '{"read_blk255",       1'b1, 32'h3FF, '0,      LINE_B};
    vecs[7] = '{"read_blk255_wrap",  1'b1, 32'h7FC, '0,      LINE_B};
    vecs[8] = '{"read_blk8_zero",    1'b1, 32'h20,  '0,      '0};

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_reset_ready", 128'(mem_ready), 128'(1));
    chk("t1_reset_valid", 128'(is_output_valid), 128'(0));
    chk("t1_reset_dout", dout, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].name, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].exp);
    end

    // T3: bus noise while busy must be ignored
    start_req(1'b1, 32'h14, '0);
    lat = 0;
    spurious = 0;
    while (!mem_ready && lat < LIMIT) begin
      lat++;
      is_input_valid = lat[0];
      mem_write      = ~lat[0];
      mem_read       = lat[1];
      addr           = $urandom;
      din            = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (!mem_ready && is_output_valid) spurious++;
    end
    idle_inputs();
    chk("t3_busy_cycles", 128'(lat), 128'(DELAY));
    chk("t3_spurious_valid", 128'(spurious), 128'(0));
    chk("t3_valid_at_done", 128'(is_output_valid), 128'(1));
    chk("t3_dout", dout, LINE_T2);
    @(negedge clk);
    chk("t3_no_extra_txn", 128'(mem_ready), 128'(1));
    run_op("t3_blk5_unchanged", 1'b1, 32'h14, '0, LINE_T2);
    run_op("t3_blk0_unchanged", 1'b1, 32'h0, '0, LINE_A);

    // T4: both or neither op bits set must be ignored
    for (int k = 0; k < 2; k++) begin
      is_input_valid = 1'b1;
      mem_read       = (k == 0);
      mem_write      = (k == 0);
      addr           = 32'h14;
      din            = '1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("t4_illegal_ready", 128'(mem_ready), 128'(1));
        chk("t4_illegal_valid", 128'(is_output_valid), 128'(0));
      end
      idle_inputs();
    end
    run_op("t4_blk5_unchanged", 1'b1, 32'h14, '0, LINE_T2);

    // T5: reset 20 cycles into a write aborts it
    start_req(1'b0, 32'hC, 128'h1);
    repeat (19) @(negedge clk);
    chk("t5_busy_before_reset", 128'(mem_ready), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_idle_after_reset", 128'(mem_ready), 128'(1));
    chk("t5_valid_after_reset", 128'(is_output_valid), 128'(0));
    @(negedge clk);
    chk("t5_still_idle", 128'(mem_ready), 128'(1));
    run_op("t5_blk3_zero", 1'b1, 32'hC, '0, '0);
    run_op("t5_blk5_cleared", 1'b1, 32'h14, '0, '0);

    // T6: read presented on the write's completion cycle is accepted at the next edge
    start_req(1'b0, 32'h40, LINE_C);
    wait_done(lat);
    chk("t6_b2b_write_latency", 128'(lat), 128'(DELAY));
    start_req(1'b1, 32'h40, '0);
    chk("t6_b2b_accepted", 128'(mem_ready), 128'(0));
    wait_done(lat);
    chk("t6_b2b_read_latency", 128'(lat), 128'(DELAY));
    chk("t6_b2b_valid", 128'(is_output_valid), 128'(1));
    chk("t6_b2b_dout", dout, LINE_C);
    @(negedge clk);
    chk("t6_b2b_valid_after", 128'(is_output_valid), 128'(0));
    chk("t6_dout_held", dout, LINE_C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
